// File: rtl/vend_controller.sv
// Multi-product vending controller: nickel credit accumulator,
// per-product pricing, refund and greedy coin-by-coin change.
module vend_controller #(
  parameter int NUM_PRODUCTS = 4,
  parameter int CREDIT_W     = 5,
  parameter int MAX_CREDIT   = 20,
  parameter logic [NUM_PRODUCTS*CREDIT_W-1:0] PRICES =
    {5'd8, 5'd7, 5'd6, 5'd5}
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [2:0]              sensor,
  input  logic [NUM_PRODUCTS-1:0] product_sel,
  input  logic                    cancel,
  input  logic                    change_ack,
  output logic [CREDIT_W-1:0]     credit,
  output logic                    release_soda,
  output logic [NUM_PRODUCTS-1:0] vend_product,
  output logic                    change_valid,
  output logic [2:0]              change_coin,
  output logic                    coin_reject,
  output logic                    short_funds,
  output logic                    busy
);

  typedef enum logic [1:0] {
    COLLECT,
    VEND,
    CHANGE
  } state_t;

  state_t state_q, state_d;

  logic [CREDIT_W-1:0]     credit_q, credit_d;
  logic [CREDIT_W-1:0]     remain_q, remain_d;
  logic [NUM_PRODUCTS-1:0] prod_q, prod_d;
  logic rel_q, rel_d;
  logic rej_q, rej_d;
  logic short_q, short_d;

  logic                sel_one;
  logic                coin_one;
  logic [CREDIT_W-1:0] price;
  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W:0]   sum;
  logic [2:0]          chg_coin;
  logic [CREDIT_W-1:0] chg_val;

  always_comb begin
    sel_one  = $onehot(product_sel);
    coin_one = $onehot(sensor);
    price    = '0;
    for (int i = 0; i < NUM_PRODUCTS; i++) begin
      if (product_sel[i]) begin
        price = PRICES[i*CREDIT_W +: CREDIT_W];
      end
    end
    case (sensor)
      3'b001:  coin_val = CREDIT_W'(5);
      3'b010:  coin_val = CREDIT_W'(2);
      3'b100:  coin_val = CREDIT_W'(1);
      default: coin_val = '0;
    endcase
    sum = {1'b0, credit_q} + {1'b0, coin_val};
    // Greedy pick on the registered remainder
    if (remain_q >= CREDIT_W'(5)) begin
      chg_coin = 3'b001;
      chg_val  = CREDIT_W'(5);
    end else if (remain_q >= CREDIT_W'(2)) begin
      chg_coin = 3'b010;
      chg_val  = CREDIT_W'(2);
    end else begin
      chg_coin = 3'b100;
      chg_val  = CREDIT_W'(1);
    end
  end

  assign change_valid = (state_q == CHANGE) &&
                        (remain_q != '0);
  assign change_coin  = change_valid ? chg_coin : 3'b000;
  assign credit       = credit_q;
  assign release_soda = rel_q;
  assign vend_product = rel_q ? prod_q : '0;
  assign coin_reject  = rej_q;
  assign short_funds  = short_q;
  assign busy         = (state_q != COLLECT);

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    remain_d = remain_q;
    prod_d   = prod_q;
    rel_d    = 1'b0;
    rej_d    = 1'b0;
    short_d  = 1'b0;
    unique case (state_q)
      COLLECT: begin
        if (cancel && (credit_q != '0)) begin
          remain_d = credit_q;
          credit_d = '0;
          state_d  = CHANGE;
          rej_d    = |sensor;
        end else if (sel_one && (credit_q >= price)) begin
          prod_d   = product_sel;
          remain_d = credit_q - price;
          credit_d = '0;
          state_d  = VEND;
          rel_d    = 1'b1;
          rej_d    = |sensor;
        end else begin
          short_d = sel_one;
          if (coin_one &&
              (sum <= (CREDIT_W+1)'(MAX_CREDIT))) begin
            credit_d = sum[CREDIT_W-1:0];
          end else begin
            rej_d = |sensor;
          end
        end
      end
      VEND: begin
        rej_d   = |sensor;
        state_d = (remain_q != '0) ? CHANGE : COLLECT;
      end
      CHANGE: begin
        rej_d = |sensor;
        if (change_ack && change_valid) begin
          remain_d = remain_q - chg_val;
          if (remain_q == chg_val) begin
            state_d = COLLECT;
          end
        end else if (remain_q == '0) begin
          state_d = COLLECT;
        end
      end
      default: begin
        state_d = COLLECT;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= COLLECT;
      credit_q <= '0;
      remain_q <= '0;
      prod_q   <= '0;
      rel_q    <= 1'b0;
      rej_q    <= 1'b0;
      short_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      remain_q <= remain_d;
      prod_q   <= prod_d;
      rel_q    <= rel_d;
      rej_q    <= rej_d;
      short_q  <= short_d;
    end
  end

endmodule

// File: tb/tb_vend_controller.sv
// Scoreboard bench for vend_controller: a transaction-level model
// predicts each cycle's outputs; a monitor compares on negedge.
module tb_vend_controller;

  localparam int MAXC = 20;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [2:0] sensor = '0;
  logic [3:0] product_sel = '0;
  logic       cancel = 1'b0;
  logic       change_ack = 1'b0;
  logic [4:0] credit;
  logic       release_soda;
  logic [3:0] vend_product;
  logic       change_valid;
  logic [2:0] change_coin;
  logic       coin_reject;
  logic       short_funds;
  logic       busy;

  vend_controller dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .sensor       (sensor),
    .product_sel  (product_sel),
    .cancel       (cancel),
    .change_ack   (change_ack),
    .credit       (credit),
    .release_soda (release_soda),
    .vend_product (vend_product),
    .change_valid (change_valid),
    .change_coin  (change_coin),
    .coin_reject  (coin_reject),
    .short_funds  (short_funds),
    .busy         (busy)
  );

  initial forever #5 clock = ~clock;

  typedef struct packed {
    logic [4:0] credit;
    logic       rel;
    logic [3:0] vp;
    logic       cv;
    logic [2:0] cc;
    logic       rj;
    logic       sf;
    logic       busy;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  int         price_tab[4] = '{5, 6, 7, 8};
  int         m_credit;
  bit         m_vend;
  int         m_prod;
  logic [2:0] m_chg[$];
  bit         m_rej;
  bit         m_short;

  localparam logic [2:0] QTR = 3'b001;
  localparam logic [2:0] DIM = 3'b010;
  localparam logic [2:0] NIC = 3'b100;

  function automatic int coin_value(logic [2:0] c);
    case (c)
      3'b001:  return 5;
      3'b010:  return 2;
      3'b100:  return 1;
      default: return 0;
    endcase
  endfunction

  function automatic obs_t actual();
    return {credit, release_soda, vend_product, change_valid,
            change_coin, coin_reject, short_funds, busy};
  endfunction

  task automatic model_reset();
    m_credit = 0;
    m_vend   = 0;
    m_prod   = 0;
    m_chg.delete();
    m_rej    = 0;
    m_short  = 0;
  endtask

  // Change owed is expanded into its coin sequence up front
  task automatic load_change(input int r);
    int left;
    left = r;
    while (left > 0) begin
      if (left >= 5) begin
        m_chg.push_back(QTR);
        left -= 5;
      end else if (left >= 2) begin
        m_chg.push_back(DIM);
        left -= 2;
      end else begin
        m_chg.push_back(NIC);
        left -= 1;
      end
    end
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    o        = '0;
    o.credit = 5'(m_credit);
    o.rel    = m_vend;
    o.vp     = m_vend ? 4'(1 << m_prod) : 4'b0;
    o.cv     = !m_vend && (m_chg.size() > 0);
    o.cc     = o.cv ? m_chg[0] : 3'b000;
    o.rj     = m_rej;
    o.sf     = m_short;
    o.busy   = m_vend || (m_chg.size() > 0);
    return o;
  endfunction

  task automatic model_step(input logic c, input logic [3:0] s,
                            input logic [2:0] sn, input logic a);
    bit was_busy;
    int idx;
    was_busy = m_vend || (m_chg.size() > 0);
    m_rej   = 0;
    m_short = 0;
    if (was_busy) begin
      m_rej = (sn != 0);
      if (m_vend) m_vend = 0;
      else if (a) void'(m_chg.pop_front());
    end else begin
      idx = 0;
      for (int i = 0; i < 4; i++) if (s[i]) idx = i;
      if (c && m_credit > 0) begin
        load_change(m_credit);
        m_credit = 0;
        m_rej = (sn != 0);
      end else if ($countones(s) == 1 &&
                   m_credit >= price_tab[idx]) begin
        m_vend = 1;
        m_prod = idx;
        load_change(m_credit - price_tab[idx]);
        m_credit = 0;
        m_rej = (sn != 0);
      end else begin
        m_short = ($countones(s) == 1);
        if ($countones(sn) == 1 &&
            m_credit + coin_value(sn) <= MAXC)
          m_credit += coin_value(sn);
        else
          m_rej = (sn != 0);
      end
    end
  endtask

  task automatic step(input logic c, input logic [3:0] s,
                      input logic [2:0] sn, input logic a);
    exp_q.push_back(model_obs());
    cancel      = c;
    product_sel = s;
    sensor      = sn;
    change_ack  = a;
    model_step(c, s, sn, a);
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 4'b0, 3'b0, 0);
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && (m_vend || m_chg.size() > 0); k++)
      step(0, 4'b0, 3'b0, 1);
    idle(1);
  endtask

  task automatic check_zero(input string name);
    obs_t a;
    a = actual();
    checks++;
    if (a === '0) passed++;
    else $display("FAIL %s act=%h exp=%h", name, a, 17'h0);
  endtask

  initial begin : monitor
    obs_t e, a;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = actual();
        checks++;
        if (a === e) passed++;
        else $display("FAIL scoreboard t=%0t act=%h exp=%h crd=%0d/%0d",
                      $time, a, e, a.credit, e.credit);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [3:0] s;
    logic [2:0] sn;
    int r;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_zero("reset");
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    step(0, 4'b0, QTR, 0);
    step(0, 4'b0, NIC, 0);
    step(0, 4'b0010, 3'b0, 0);
    idle(3);

    step(0, 4'b0, QTR, 0);
    step(0, 4'b0, QTR, 0);
    step(0, 4'b0001, 3'b0, 0);
    idle(3);
    step(0, 4'b0, 3'b0, 1);
    idle(2);

    repeat (4) step(0, 4'b0, DIM, 0);
    step(0, 4'b1000, 3'b0, 0);
    idle(2);
    step(0, 4'b0, DIM, 0);
    step(0, 4'b0, NIC, 0);
    step(0, 4'b0001, 3'b0, 0);
    idle(2);
    step(1, 4'b0, 3'b0, 0);
    drain();

    repeat (3) step(0, 4'b0, QTR, 0);
    step(0, 4'b0, DIM, 0);
    step(0, 4'b0, NIC, 0);
    step(0, 4'b0, QTR, 0);
    repeat (3) step(0, 4'b0, NIC, 0);
    step(0, 4'b0, 3'b011, 0);
    idle(1);
    step(1, 4'b0, 3'b0, 0);
    drain();

    step(0, 4'b0, QTR, 0);
    step(0, 4'b0001, NIC, 0);
    idle(2);
    step(0, 4'b0, QTR, 0);
    step(0, 4'b0, QTR, 0);
    step(0, 4'b0001, 3'b0, 0);
    step(0, 4'b0, 3'b0, 0);
    step(0, 4'b0010, DIM, 0);
    step(1, 4'b0100, 3'b0, 0);
    drain();

    step(0, 4'b0, QTR, 0);
    step(0, 4'b0, DIM, 0);
    step(1, 4'b0, 3'b0, 0);
    idle(2);
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check_zero("async_reset");
    @(posedge clock);
    #1;
    check_zero("held_reset");
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    model_reset();
    idle(2);

    repeat (1500) begin
      r = $urandom_range(0, 15);
      if (r < 2) s = 4'(1 << $urandom_range(0, 3));
      else if (r == 2) s = 4'($urandom_range(0, 15));
      else s = 4'b0;
      r = $urandom_range(0, 9);
      if (r < 5) sn = 3'(1 << $urandom_range(0, 2));
      else if (r == 5) sn = 3'($urandom_range(0, 7));
      else sn = 3'b0;
      step(($urandom_range(0, 39) == 0), s, sn,
           1'($urandom_range(0, 1)));
    end
    drain();
    idle(2);
    @(negedge clock);
    #1;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
